// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit paths.
//   - uart_state_e : receiver FSM encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   - OVERSAMPLE   : oversampling ratio per bit
//   - MID_SAMPLE   : sample count nearest the bit centre
//   - DATA_BITS_7 / DATA_BITS_8 : character lengths selectable per frame
//   - DECIDE_SAMPLE: sample count at which bit decisions and state actions occur
//   - maj3()       : 2-of-3 majority vote
// Optional build macro: UART_RX_MAJORITY_EN moves the decision point one
// sample later so that counts 6, 7 and 8 can be voted.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   localparam int OVERSAMPLE  = 16;
   localparam int MID_SAMPLE  = 7;
   localparam int DATA_BITS_7 = 7;
   localparam int DATA_BITS_8 = 8;

   localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] PRE_SAMPLE  = 4'(MID_SAMPLE - 1);
   localparam logic [3:0] MID_CNT     = 4'(MID_SAMPLE);
`ifdef UART_RX_MAJORITY_EN
   localparam logic [3:0] DECIDE_SAMPLE = 4'(MID_SAMPLE + 1);
`else
   localparam logic [3:0] DECIDE_SAMPLE = 4'(MID_SAMPLE);
`endif

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: parallel character handshake between the UART receiver and
// the host-side RX buffer.
//   m_data_o    : received character (bit 7 = 0 for 7-bit frames)
//   m_valid_o   : character available
//   m_ready_i   : consumer accepts
//   frame_err_o : stop-bit error, qualified by m_valid_o
//   overrun_o   : sticky, a character was dropped while one was pending
// Handshake: a character transfers on every clock edge where m_valid_o and
// m_ready_i are both high; while m_valid_o is high and m_ready_i is low,
// m_data_o and frame_err_o hold steady and m_valid_o stays high.
interface uart_rx_if;
   logic [7:0] m_data_o;
   logic       m_valid_o;
   logic       m_ready_i;
   logic       frame_err_o;
   logic       overrun_o;

   modport master (
      output m_data_o,
      output m_valid_o,
      output frame_err_o,
      output overrun_o,
      input  m_ready_i
   );

   modport slave (
      input  m_data_o,
      input  m_valid_o,
      input  frame_err_o,
      input  overrun_o,
      output m_ready_i
   );
endinterface

// File: rtl/uart_os_tick_gen.sv
// uart_os_tick_gen: clearable divider producing a one-clock oversample tick
// every max(div_i,1) clocks. Usable for both RX and TX baud paths.
//   clk_i     : system clock
//   s_rst_n_i : synchronous active-low reset
//   clear_i   : holds the divider at zero and suppresses the tick
//   div_i     : clocks per tick, 0 behaves as 1
//   tick_o    : one-clock pulse
module uart_os_tick_gen #(
   parameter int DIV_W = 16
) (
   input  logic             clk_i,
   input  logic             s_rst_n_i,
   input  logic             clear_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             tick_o
);

   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] w_div_m1;

   assign w_div_m1 = (div_i == '0) ? '0 : div_i - 1'b1;
   // >= keeps the divider from running away if the count ever exceeds the
   // terminal value.
   assign tick_o   = !clear_i && (r_cnt >= w_div_m1);

   always_ff @(posedge clk_i) begin
      if (!s_rst_n_i) begin
         r_cnt <= '0;
      end else if (clear_i || tick_o) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver with 16x oversampling, mid-bit sampling and
// start-bit glitch rejection. Frames of 7/8 data bits and 1/2 stop bits.
//   clk_i          : system clock
//   s_rst_n_i      : synchronous active-low reset
//   enable_i       : receiver enable; low aborts the frame and holds IDLE
//   rx_i           : asynchronous serial input, idle high
//   baud_div_i     : clocks per 1/16 bit (0 behaves as 1)
//   data_bit_num_i : 1 = 7 data bits, 0 = 8
//   stop_bit_num_i : 1 = two stop bits, 0 = one
//   busy_o         : high whenever the FSM is not IDLE
//   dbg_state_o    : current FSM state
//   m_if           : character output handshake (uart_rx_if.master)
// Optional build macro: UART_RX_MAJORITY_EN votes samples 6/7/8 and acts at
// sample 8 instead of taking a single sample at 7.
module uart_rx
   import uart_pkg::*;
#(
   parameter int BAUD_DIV_W = 16
) (
   input  logic                  clk_i,
   input  logic                  s_rst_n_i,
   input  logic                  enable_i,
   input  logic                  rx_i,
   input  logic [BAUD_DIV_W-1:0] baud_div_i,
   input  logic                  data_bit_num_i,
   input  logic                  stop_bit_num_i,
   output logic                  busy_o,
   output uart_state_e           dbg_state_o,
   uart_rx_if.master             m_if
);

   // synchronizer and frame state
   logic                  r_rx_meta;
   logic                  r_rx_sync;
   uart_state_e           r_state;
   uart_state_e           w_state_nxt;
   logic [3:0]            r_sample_cnt;
   logic [2:0]            r_bit_cnt;
   logic [7:0]            r_shift;
   logic [BAUD_DIV_W-1:0] r_div;
   logic                  r_seven;
   logic                  r_two_stop;
   logic                  r_stop_idx;
   logic                  r_ferr;

   // output registers
   logic [7:0]            r_data;
   logic                  r_valid;
   logic                  r_frame_err;
   logic                  r_overrun;

   logic w_os_tick;
   logic w_tick_clear;
   logic w_decide;
   logic w_last;
   logic w_bit;
   logic w_last_data;
   logic w_last_stop;
   logic w_start;
   logic w_shift_en;
   logic w_commit;
   logic [7:0] w_char;

   assign w_tick_clear = (r_state == ST_IDLE) || !enable_i;

   uart_os_tick_gen #(.DIV_W(BAUD_DIV_W)) u_tick_gen (
      .clk_i     (clk_i),
      .s_rst_n_i (s_rst_n_i),
      .clear_i   (w_tick_clear),
      .div_i     (r_div),
      .tick_o    (w_os_tick)
   );

   assign w_decide    = w_os_tick && (r_sample_cnt == DECIDE_SAMPLE);
   assign w_last      = w_os_tick && (r_sample_cnt == LAST_SAMPLE);
   assign w_last_data = (r_bit_cnt == (r_seven ? 3'd6 : 3'd7));
   assign w_last_stop = (r_stop_idx == r_two_stop);

`ifdef UART_RX_MAJORITY_EN
   logic r_s6;
   logic r_s7;

   always_ff @(posedge clk_i) begin
      if (!s_rst_n_i) begin
         r_s6 <= 1'b1;
         r_s7 <= 1'b1;
      end else if (w_os_tick) begin
         if (r_sample_cnt == PRE_SAMPLE) r_s6 <= r_rx_sync;
         if (r_sample_cnt == MID_CNT)    r_s7 <= r_rx_sync;
      end
   end

   // count-8 sample is the live synchronized value at the decision tick
   assign w_bit = maj3(r_s6, r_s7, r_rx_sync);
`else
   assign w_bit = r_rx_sync;
`endif

   // 7-bit characters have been shifted one place short of the LSB
   assign w_char = r_seven ? {1'b0, r_shift[7:1]} : r_shift;

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_shift_en  = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!r_rx_sync) begin
               w_state_nxt = ST_START;
               w_start     = 1'b1;
            end
         end
         ST_START: begin
            if (w_decide && w_bit) begin
               w_state_nxt = ST_IDLE;
            end else if (w_last) begin
               w_state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            w_shift_en = w_decide;
            if (w_last && w_last_data) begin
               w_state_nxt = ST_STOP;
            end
         end
         ST_STOP: begin
            // committing at the last stop's mid-sample leaves half a bit to
            // catch a back-to-back start edge
            if (w_decide && w_last_stop) begin
               w_commit    = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (!enable_i) begin
         w_state_nxt = ST_IDLE;
         w_start     = 1'b0;
         w_shift_en  = 1'b0;
         w_commit    = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!s_rst_n_i) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_state   <= ST_IDLE;
      end else begin
         r_rx_meta <= rx_i;
         r_rx_sync <= r_rx_meta;
         r_state   <= w_state_nxt;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!s_rst_n_i) begin
         r_sample_cnt <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_div        <= '0;
         r_seven      <= 1'b0;
         r_two_stop   <= 1'b0;
         r_stop_idx   <= 1'b0;
         r_ferr       <= 1'b0;
      end else if (!enable_i || w_start) begin
         r_sample_cnt <= '0;
         r_bit_cnt    <= '0;
         r_stop_idx   <= 1'b0;
         r_ferr       <= 1'b0;
         if (w_start) begin
            r_shift    <= '0;
            r_div      <= baud_div_i;
            r_seven    <= data_bit_num_i;
            r_two_stop <= stop_bit_num_i;
         end
      end else begin
         if (w_os_tick) r_sample_cnt <= r_sample_cnt + 1'b1;
         if (w_shift_en) r_shift <= {w_bit, r_shift[7:1]};
         if ((r_state == ST_DATA) && w_last) r_bit_cnt <= r_bit_cnt + 1'b1;
         if ((r_state == ST_STOP) && w_last) r_stop_idx <= 1'b1;
         if ((r_state == ST_STOP) && w_decide && !w_bit) r_ferr <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!s_rst_n_i) begin
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (!enable_i) r_overrun <= 1'b0;
         if (w_commit) begin
            if (!r_valid || m_if.m_ready_i) begin
               r_data      <= w_char;
               r_frame_err <= r_ferr | !w_bit;
               r_valid     <= 1'b1;
            end else begin
               r_overrun   <= 1'b1;
            end
         end else if (r_valid && m_if.m_ready_i) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign m_if.m_data_o    = r_data;
   assign m_if.m_valid_o   = r_valid;
   assign m_if.frame_err_o = r_frame_err;
   assign m_if.overrun_o   = r_overrun;
   assign busy_o           = (r_state != ST_IDLE);
   assign dbg_state_o      = r_state;

endmodule
